piso_bit_serializer: RTL and testbench

//  Parallel-in/serial-out stage feeding the 1011 sequence detector's d_in.

---
 rtl/piso_bit_serializer.sv | 205 ++++++++++++++++++++
 tb/tb_piso_bit_serializer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// piso_bit_serializer
//
// Parallel-in / serial-out stage that feeds the d_in input of the 1011
// sequence detector. WIDTH-bit words arrive over a valid/ready handshake and
// leave one bit per clock on ser_out. A one-word holding buffer lets a second
// word wait while the current word is shifting, so back-to-back words stream
// with no idle bit between them.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: data_in[WIDTH-1] leaves first; 0: data_in[0] leaves first
//   CNT_W      width of the sent-word counter
//
// Ports
//   clk         in   1      clock, all state changes on the rising edge
//   rst         in   1      asynchronous reset, active low (0 = reset)
//   data_in     in   WIDTH  parallel word
//   data_valid  in   1      data_in holds a word to transfer
//   data_ready  out  1      a word can be accepted this cycle (registered)
//   ser_out     out  1      serial bit, 0 whenever ser_valid is 0
//   ser_valid   out  1      ser_out carries a data bit this cycle
//   word_done   out  1      high while the last bit of a word is on ser_out
//   word_cnt    out  CNT_W  number of fully transmitted words, wraps silently
//
// All outputs come straight from flops. The next value of every output is
// derived from the next value of the internal state, so ser_out/word_done
// always describe the bit that the shift register presents after the edge.
// -----------------------------------------------------------------------------
module piso_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
  localparam logic [BCNT_W-1:0] BCNT_ZERO = {BCNT_W{1'b0}};
  localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WIDTH-1:0]  WORD_ZERO = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit presented at the output end of the shift register.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    logic b;
    if (MSB_FIRST) begin
      b = w[WIDTH-1];
    end else begin
      b = w[0];
    end
    return b;
  endfunction

  // Advance the shift register by one bit toward the output end.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    if (MSB_FIRST) begin
      r = {w[WIDTH-2:0], 1'b0};
    end else begin
      r = {1'b0, w[WIDTH-1:1]};
    end
    return r;
  endfunction

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   shreg_q,     shreg_d;
  logic [BCNT_W-1:0]  bcnt_q,      bcnt_d;
  logic [WIDTH-1:0]   hold_q,      hold_d;
  logic               hold_full_q, hold_full_d;
  logic [CNT_W-1:0]   word_cnt_q,  word_cnt_d;
  logic               ready_q,     ready_d;
  logic               ser_out_q,   ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               word_done_q, word_done_d;
  logic               accept_s;

  // Handshake completes when the source offers a word and the registered ready is high.
  assign accept_s = data_valid & ready_q;

  // Next-state logic: FSM, shift register, bit counter, hold buffer and word counter.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bcnt_d      = bcnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    word_cnt_d  = word_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // The hold buffer is always empty here, so a new word goes straight to the shifter.
        if (accept_s) begin
          shreg_d = data_in;
          bcnt_d  = BCNT_LAST;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (bcnt_q == BCNT_ZERO) begin
          // Last bit of the current word leaves on this edge.
          word_cnt_d = word_cnt_q + CNT_ONE;
          if (hold_full_q) begin
            shreg_d = hold_q;
            bcnt_d  = BCNT_LAST;
            // A concurrent accept refills the hold buffer; ready stays low.
            if (accept_s) begin
              hold_d      = data_in;
              hold_full_d = 1'b1;
            end else begin
              hold_full_d = 1'b0;
            end
          end else if (accept_s) begin
            shreg_d = data_in;
            bcnt_d  = BCNT_LAST;
          end else begin
            shreg_d = WORD_ZERO;
            bcnt_d  = BCNT_ZERO;
            state_d = ST_IDLE;
          end
        end else begin
          shreg_d = shift_word(shreg_q);
          bcnt_d  = bcnt_q - BCNT_ONE;
          if (accept_s) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end else begin
            hold_full_d = hold_full_q;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        shreg_d     = WORD_ZERO;
        bcnt_d      = BCNT_ZERO;
        hold_full_d = 1'b0;
      end
    endcase
  end

  // Next values of the registered outputs, taken from the next internal state.
  always_comb begin
    ser_valid_d = (state_d == ST_SHIFT);
    if (ser_valid_d) begin
      ser_out_d   = out_bit(shreg_d);
      word_done_d = (bcnt_d == BCNT_ZERO);
    end else begin
      ser_out_d   = 1'b0;
      word_done_d = 1'b0;
    end
    ready_d = ~hold_full_d;
  end

  // State and output registers; reset clears everything, including any buffered word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= WORD_ZERO;
      bcnt_q      <= BCNT_ZERO;
      hold_q      <= WORD_ZERO;
      hold_full_q <= 1'b0;
      word_cnt_q  <= {CNT_W{1'b0}};
      ready_q     <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bcnt_q      <= bcnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      word_cnt_q  <= word_cnt_d;
      ready_q     <= ready_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
    end
  end

  assign data_ready = ready_q;
  assign ser_out    = ser_out_q;
  assign ser_valid  = ser_valid_q;
  assign word_done  = word_done_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// Bench for piso_bit_serializer. Three instances share clock and reset:
//   inst 0: WIDTH=8, MSB_FIRST=1, CNT_W=16
//   inst 1: WIDTH=8, MSB_FIRST=0, CNT_W=16
//   inst 2: WIDTH=8, MSB_FIRST=1, CNT_W=4
// The reference model is a per-instance bit queue: each accepted word pushes
// its eight bits in transmit order; every cycle the bits still queued must be
// streaming, one per clock, with word_done on each word's last bit.
// -----------------------------------------------------------------------------
module tb_piso_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] din [3];
  logic       dv  [3];
  logic       dr  [3];
  logic       so  [3];
  logic       sv  [3];
  logic       wd  [3];
  logic [15:0] wc0;
  logic [15:0] wc1;
  logic [3:0]  wc2;

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
    .clk(clk), .rst(rst), .data_in(din[0]), .data_valid(dv[0]), .data_ready(dr[0]),
    .ser_out(so[0]), .ser_valid(sv[0]), .word_done(wd[0]), .word_cnt(wc0));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(16)) u_lsb (
    .clk(clk), .rst(rst), .data_in(din[1]), .data_valid(dv[1]), .data_ready(dr[1]),
    .ser_out(so[1]), .ser_valid(sv[1]), .word_done(wd[1]), .word_cnt(wc1));

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst(rst), .data_in(din[2]), .data_valid(dv[2]), .data_ready(dr[2]),
    .ser_out(so[2]), .ser_valid(sv[2]), .word_done(wd[2]), .word_cnt(wc2));

  // Reference model state
  logic mbuf [3][256];
  int   wr_p [3];
  int   rd_p [3];
  logic mrdy [3];
  int   exp_cnt [3];
  int   cmask [3];
  logic pend [3];
  logic last_acc [3];

  // Observation records (what actually came out, compared to constants)
  logic [255:0] obs_bits [3];
  int   vcount [3];
  int   runs [3];
  int   det [3];
  logic prev_sv [3];
  logic [3:0] hist [3];

  logic [7:0] wq [32];
  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wc_of(input int i);
    case (i)
      0:       return {16'h0000, wc0};
      1:       return {16'h0000, wc1};
      default: return {28'h0000000, wc2};
    endcase
  endfunction

  // Queue the bits of an accepted word in the order they must leave.
  task automatic push_word(input int i, input logic [7:0] w);
    for (int b = 0; b < 8; b++) begin
      mbuf[i][wr_p[i] & 255] = (i == 1) ? w[b] : w[7-b];
      wr_p[i]++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      wr_p[i] = 0; rd_p[i] = 0; mrdy[i] = 1'b0;
      exp_cnt[i] = 0; pend[i] = 1'b0; last_acc[i] = 1'b0;
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) begin
      obs_bits[i] = '0; vcount[i] = 0; runs[i] = 0; det[i] = 0;
    end
  endtask

  // Compare every instance against the model just after a clock edge.
  task automatic sample();
    int   size;
    logic exp_v;
    logic exp_done;
    for (int i = 0; i < 3; i++) begin
      size  = wr_p[i] - rd_p[i];
      exp_v = (size > 0);
      chk($sformatf("ser_valid[%0d]", i), {31'd0, sv[i]}, {31'd0, exp_v});
      if (exp_v) begin
        exp_done = ((size % 8) == 1);
        chk($sformatf("ser_out[%0d]", i), {31'd0, so[i]}, {31'd0, mbuf[i][rd_p[i] & 255]});
        chk($sformatf("word_done[%0d]", i), {31'd0, wd[i]}, {31'd0, exp_done});
        rd_p[i]++;
        if (exp_done) pend[i] = 1'b1;
      end else begin
        chk($sformatf("ser_out_idle[%0d]", i), {31'd0, so[i]}, 32'd0);
        chk($sformatf("word_done_idle[%0d]", i), {31'd0, wd[i]}, 32'd0);
      end
      // Ready is low only while a second word waits behind the shifting one.
      mrdy[i] = rst && (size <= 8);
      chk($sformatf("data_ready[%0d]", i), {31'd0, dr[i]}, {31'd0, mrdy[i]});
      chk($sformatf("word_cnt[%0d]", i), wc_of(i), exp_cnt[i]);
      if (sv[i] === 1'b1) begin
        obs_bits[i] = {obs_bits[i][254:0], so[i]};
        vcount[i]++;
        if (prev_sv[i] !== 1'b1) runs[i]++;
      end
      prev_sv[i] = sv[i];
      hist[i] = {hist[i][2:0], so[i]};
      if (hist[i] == 4'b1011) det[i]++;
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      last_acc[i] = rst && dv[i] && mrdy[i];
      if (rst && pend[i]) begin
        exp_cnt[i] = (exp_cnt[i] + 1) & cmask[i];
        pend[i] = 1'b0;
      end
      if (last_acc[i]) push_word(i, din[i]);
    end
    @(posedge clk);
    #1;
    sample();
  endtask

  // Offer wq[0..n-1] with valid held high, advancing on each accept.
  task automatic send_list(input int i, input int n);
    int k;
    int b;
    k = 0; b = 0;
    din[i] = wq[0];
    dv[i]  = 1'b1;
    while (k < n && b < 400) begin
      tick();
      b++;
      if (last_acc[i]) begin
        k++;
        if (k < n) din[i] = wq[k];
      end
    end
    dv[i] = 1'b0;
    chk($sformatf("send_accepts[%0d]", i), k, n);
  endtask

  task automatic drain(input int i);
    int b;
    b = 0;
    while ((wr_p[i] != rd_p[i] || pend[i]) && b < 200) begin
      tick();
      b++;
    end
    chk($sformatf("drain_in_time[%0d]", i), {31'd0, (b < 200)}, 32'd1);
  endtask

  initial begin
    checks = 0; errors = 0;
    cmask[0] = 16'hFFFF; cmask[1] = 16'hFFFF; cmask[2] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      din[i] = 8'h00; dv[i] = 1'b0; prev_sv[i] = 1'b0; hist[i] = 4'h0;
    end
    model_reset();
    clear_obs();

    // Reset: outputs at reset values, valid ignored while in reset.
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    sample();
    din[0] = 8'hFF; dv[0] = 1'b1;
    tick();
    tick();
    dv[0] = 1'b0;
    rst = 1'b1;
    tick();

    // Single word 0xB0: 1,0,1,1,0,0,0,0 and one 1011 hit.
    clear_obs();
    wq[0] = 8'hB0;
    send_list(0, 1);
    drain(0);
    chk("t1_bits", {24'd0, obs_bits[0][7:0]}, 32'h000000B0);
    chk("t1_valid_cycles", vcount[0], 8);
    chk("t1_runs", runs[0], 1);
    chk("t1_detect", det[0], 1);
    chk("t1_word_cnt", {16'd0, wc0}, 32'd1);

    // Back-to-back 0xB0, 0xB6: 16 contiguous bits, three 1011 hits.
    clear_obs();
    wq[0] = 8'hB0; wq[1] = 8'hB6;
    send_list(0, 2);
    drain(0);
    chk("t2_bits", {16'd0, obs_bits[0][15:0]}, 32'h0000B0B6);
    chk("t2_valid_cycles", vcount[0], 16);
    chk("t2_runs", runs[0], 1);
    chk("t2_detect", det[0], 3);
    chk("t2_word_cnt", {16'd0, wc0}, 32'd3);

    // Reset during bit 4 of 0xFF, then a clean 0xA5.
    clear_obs();
    wq[0] = 8'hFF;
    send_list(0, 1);
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("t4_ser_out_async", {31'd0, so[0]}, 32'd0);
    chk("t4_ser_valid_async", {31'd0, sv[0]}, 32'd0);
    chk("t4_ready_async", {31'd0, dr[0]}, 32'd0);
    chk("t4_word_cnt_async", {16'd0, wc0}, 32'd0);
    model_reset();
    tick();
    tick();
    rst = 1'b1;
    tick();
    clear_obs();
    wq[0] = 8'hA5;
    send_list(0, 1);
    drain(0);
    chk("t4_bits", {24'd0, obs_bits[0][7:0]}, 32'h000000A5);
    chk("t4_word_cnt", {16'd0, wc0}, 32'd1);

    // Three random words queued: 24 contiguous bits, count 1 + 3.
    clear_obs();
    for (int k = 0; k < 3; k++) wq[k] = 8'($urandom_range(0, 255));
    send_list(0, 3);
    drain(0);
    chk("t3_bits", {8'd0, obs_bits[0][23:0]}, {8'd0, wq[0], wq[1], wq[2]});
    chk("t3_valid_cycles", vcount[0], 24);
    chk("t3_runs", runs[0], 1);
    chk("t3_word_cnt", {16'd0, wc0}, 32'd4);

    // LSB-first 0x0D leaves as 1,0,1,1,0,0,0,0.
    clear_obs();
    wq[0] = 8'h0D;
    send_list(1, 1);
    drain(1);
    chk("t5_bits", {24'd0, obs_bits[1][7:0]}, 32'h000000B0);
    chk("t5_detect", det[1], 1);
    chk("t5_word_cnt", {16'd0, wc1}, 32'd1);

    // 4-bit counter over 17 words wraps to 1 with no gap in the stream.
    clear_obs();
    for (int k = 0; k < 17; k++) wq[k] = 8'($urandom_range(0, 255));
    send_list(2, 17);
    drain(2);
    chk("t6_valid_cycles", vcount[2], 136);
    chk("t6_runs", runs[2], 1);
    chk("t6_word_cnt", {28'd0, wc2}, 32'd1);

    // Random traffic on all instances against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        din[i] = 8'($urandom_range(0, 255));
        dv[i]  = ($urandom_range(0, 2) != 0);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) dv[i] = 1'b0;
    drain(0);
    drain(1);
    drain(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
